memory_bank: RTL and testbench
==============================

Name: memory_bank

Overview:
Parametrised, word-organised instruction/data memory with two ports.
- Fetch port: combinational, read-only.
- Data port: Req/Ready handshake, byte-enable writes, registered read data, per-access error response.
- Clear engine: a multi-cycle FSM zeroes the data region after reset or on request, leaving the low instruction region intact.
- Sits between the pipeline's IF/MEM stages and the shared storage array.

Parameters:
DATA_W, 32, data word width in bits; multiple of 8, power of two.
DEPTH, 256, number of words.
IDX_W, 8, word-index width; equals log2(DEPTH).
ADDR_W, 32, byte-address width.
INST_WORDS, 32, words [0, INST_WORDS) form the instruction region and are never cleared.
INST_WP, 1, when 1 the data port cannot write the instruction region.

Ports:
clk  in  1  clock; all state changes on rising edge
reset  in  1  asynchronous active-low reset (0 = in reset)
Fetch_addr  in  ADDR_W  fetch byte address
Fetch_data  out  DATA_W  word at Fetch_addr, combinational; 0 if out of range
Req  in  1  data access request
MemWrite  in  1  1 = write, 0 = read; qualified by Req
Byte_en  in  DATA_W/8  write lane enables; ignored on reads
Address  in  ADDR_W  data byte address
Write_data  in  DATA_W  write data
Ready  out  1  access accepted on this edge when Req && Ready
Mem_data  out  DATA_W  registered read data
Rvalid  out  1  one-cycle response strobe, 1 cycle after acceptance (reads and writes)
Resp_err  out  1  error flag, valid with Rvalid
Clear_req  in  1  request re-clear of data region
Busy  out  1  clear engine running

Behaviour:
Addressing:
- OFF = log2(DATA_W/8).
- Word index = Address[IDX_W+OFF-1:OFF]; the same rule applies to Fetch_addr.
- Misaligned: Address[OFF-1:0] != 0.
- Out of range: Address[ADDR_W-1:IDX_W+OFF] != 0.
- Protected: INST_WP==1 && MemWrite && index < INST_WORDS.
- Any of the three -> Resp_err=1 with Rvalid, no array write, Mem_data=0.

Reset (reset==0, asynchronous):
- Ready=0, Rvalid=0, Resp_err=0, Mem_data=0.
- Busy=1, state=CLEAR, clear pointer=INST_WORDS.
- Array contents are not reset; the instruction region is retained.
- If INST_WORDS >= DEPTH: state=READY, Busy=0, Ready=1 instead.

FSM states: CLEAR, READY.
- CLEAR: each cycle write 0 to word[ptr], ptr+1. After the write to DEPTH-1, go to READY next edge.
  - Duration is DEPTH-INST_WORDS cycles: 224 at defaults.
  - Ready=0, Busy=1. Req ignored (no Rvalid). Clear_req ignored (no restart).
- READY: Ready=1, Busy=0.
  - Clear_req=1 -> CLEAR next edge with ptr=INST_WORDS.
  - Req in the same cycle as Clear_req is still accepted and completes; access has priority.
- Reset asserted mid-clear -> clear restarts from INST_WORDS after deassertion.

Data access (accepted at edge T):
- Write: byte lane k of word[idx] <= Write_data lane k where Byte_en[k]=1; other lanes keep old value.
  - Rvalid=1 at T+1; Mem_data keeps its previous value.
- Read: Mem_data <= word[idx] at T; Rvalid=1 at T+1.
- Back-to-back accepts every cycle; Rvalid stays high continuously.
- A read accepted the cycle after a write to the same word returns the new data.
- Byte_en=0 write: no change, Resp_err=0.
- Rvalid and Resp_err clear the cycle after any cycle with no accepted access.

Fetch port:
- Pure combinational read; valid in both states.
- Reflects writes and clears from the following cycle.
- Fetch_data reads 0 for a word the same cycle the clear engine zeroes it (after the edge).
- No error output on this port.

Test Plan:
- Preload word 40=32'hDEADBEEF and word 5=32'h12345678, pulse reset low 2 cycles -> Busy=1 exactly 224 cycles then Ready=1; read 0xA0 -> 0; Fetch_addr 0x14 -> 32'h12345678.
- After clear, write 0x100 data 32'hAABBCCDD Byte_en=4'b0101, then read 0x100 next cycle -> Rvalid each cycle, Mem_data=32'h00BB00DD, Resp_err=0.
- Read 0x102 (misaligned), 0x400 (out of range), write 0x10 (protected, INST_WP=1) -> Resp_err=1 each, Mem_data=0, word 4 unchanged.
- Assert Req (read 0x100) and Clear_req same cycle -> Rvalid next cycle with 32'h00BB00DD, Busy=1 for 224 cycles, then word 64 reads 0, word 5 still 32'h12345678.
- Assert reset low at cycle 100 of a clear, release -> full 224-cycle clear again, Rvalid=0 throughout, Req during CLEAR never answered.
- INST_WORDS=DEPTH build: reset -> Ready=1 first cycle after release, Busy never asserted.

Source files
------------

// File: rtl/memory_bank.sv
// memory_bank: word-organised instruction/data store.
// Combinational fetch port, handshaked data port with byte-enable writes and
// a registered response, and a clear engine that zeroes the data region
// [INST_WORDS, DEPTH) after reset or on request.
module memory_bank #(
   parameter int DATA_W     = 32,
   parameter int DEPTH      = 256,
   parameter int IDX_W      = 8,
   parameter int ADDR_W     = 32,
   parameter int INST_WORDS = 32,
   parameter int INST_WP    = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   Fetch_addr,
   output logic [DATA_W-1:0]   Fetch_data,
   input  logic                Req,
   input  logic                MemWrite,
   input  logic [DATA_W/8-1:0] Byte_en,
   input  logic [ADDR_W-1:0]   Address,
   input  logic [DATA_W-1:0]   Write_data,
   output logic                Ready,
   output logic [DATA_W-1:0]   Mem_data,
   output logic                Rvalid,
   output logic                Resp_err,
   input  logic                Clear_req,
   output logic                Busy
);

   localparam int NB  = DATA_W / 8;
   localparam int OFF = $clog2(NB);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << OFF) - 1);
   localparam logic [IDX_W:0]    INST_LIM   = (IDX_W+1)'(INST_WORDS);
   localparam logic [IDX_W-1:0]  PTR_INIT   = IDX_W'(INST_WORDS);
   localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(DEPTH - 1);
   // With no data region there is nothing to clear: stay in READY for good.
   localparam bit                NO_CLEAR   = (INST_WORDS >= DEPTH);

   typedef enum logic {CLEAR, READY} state_t;

   logic [DATA_W-1:0] mem_q [DEPTH];

   state_t            state_q, state_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic              rvalid_q, rvalid_d;
   logic              err_q, err_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic              mem_we;
   logic [IDX_W-1:0]  mem_waddr;
   logic [DATA_W-1:0] mem_wdata;

   logic [IDX_W-1:0]  acc_idx;
   logic [DATA_W-1:0] acc_word;
   logic              acc_err;
   logic              accept;
   logic [IDX_W-1:0]  fetch_idx;
   logic              fetch_oor;

   // Data-port decode: index, alignment, range and write-protect checks
   always_comb begin
      acc_idx  = Address[IDX_W+OFF-1:OFF];
      acc_word = mem_q[acc_idx];
      acc_err  = (|(Address & ALIGN_MASK)) ||
                 (|(Address >> (IDX_W + OFF))) ||
                 ((INST_WP != 0) && MemWrite && ({1'b0, acc_idx} < INST_LIM));
      accept   = Req && (state_q == READY);
   end

   // Fetch port: plain combinational read, zero when out of range
   always_comb begin
      fetch_idx  = IDX_W'(Fetch_addr >> OFF);
      fetch_oor  = |(Fetch_addr >> (IDX_W + OFF));
      Fetch_data = fetch_oor ? '0 : mem_q[fetch_idx];
   end

   // Next state, clear sweep, access response and the single array write port
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      rvalid_d  = accept;
      err_d     = accept && acc_err;
      rdata_d   = rdata_q;
      mem_we    = 1'b0;
      mem_waddr = ptr_q;
      mem_wdata = '0;

      if (state_q == CLEAR) begin
         mem_we = 1'b1;
         ptr_d  = ptr_q + 1'b1;
         if (ptr_q == LAST_IDX) state_d = READY;
      end else if (Clear_req && !NO_CLEAR) begin
         state_d = CLEAR;
         ptr_d   = PTR_INIT;
      end

      // Accesses only happen in READY, so they never collide with the sweep.
      if (accept) begin
         if (acc_err) begin
            rdata_d = '0;
         end else if (!MemWrite) begin
            rdata_d = acc_word;
         end else begin
            mem_we    = 1'b1;
            mem_waddr = acc_idx;
            for (int k = 0; k < NB; k++)
               mem_wdata[k*8 +: 8] = Byte_en[k] ? Write_data[k*8 +: 8] : acc_word[k*8 +: 8];
         end
      end
   end

   // Control and response registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= NO_CLEAR ? READY : CLEAR;
         ptr_q    <= PTR_INIT;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         rvalid_q <= rvalid_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   // Storage array: not reset so the instruction region survives reset
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[mem_waddr] <= mem_wdata;
   end

   assign Ready    = (state_q == READY);
   assign Busy     = (state_q == CLEAR);
   assign Rvalid   = rvalid_q;
   assign Resp_err = err_q;
   assign Mem_data = rdata_q;

endmodule

// File: tb/tb_memory_bank.sv
// Directed bench for memory_bank. Three builds share one stimulus stream:
//   dut    - defaults (instruction region write-protected)
//   dut_nw - INST_WP=0, so the instruction region can be preloaded
//   dut_fl - INST_WORDS=DEPTH, no data region to clear
module tb_memory_bank;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Fetch_addr;
   logic        Req;
   logic        MemWrite;
   logic [3:0]  Byte_en;
   logic [31:0] Address;
   logic [31:0] Write_data;
   logic        Clear_req;

   logic [31:0] f_a, md_a, f_n, md_n, f_f, md_f;
   logic        rdy_a, rv_a, er_a, bz_a;
   logic        rdy_n, rv_n, er_n, bz_n;
   logic        rdy_f, rv_f, er_f, bz_f;

   int ncmp  = 0;
   int nfail = 0;
   bit full_busy_seen = 1'b0;

   always #5 clk = ~clk;

   memory_bank dut (
      .clk(clk), .reset(reset), .Fetch_addr(Fetch_addr), .Fetch_data(f_a),
      .Req(Req), .MemWrite(MemWrite), .Byte_en(Byte_en), .Address(Address),
      .Write_data(Write_data), .Ready(rdy_a), .Mem_data(md_a), .Rvalid(rv_a),
      .Resp_err(er_a), .Clear_req(Clear_req), .Busy(bz_a));

   memory_bank #(.INST_WP(0)) dut_nw (
      .clk(clk), .reset(reset), .Fetch_addr(Fetch_addr), .Fetch_data(f_n),
      .Req(Req), .MemWrite(MemWrite), .Byte_en(Byte_en), .Address(Address),
      .Write_data(Write_data), .Ready(rdy_n), .Mem_data(md_n), .Rvalid(rv_n),
      .Resp_err(er_n), .Clear_req(Clear_req), .Busy(bz_n));

   memory_bank #(.INST_WORDS(256)) dut_fl (
      .clk(clk), .reset(reset), .Fetch_addr(Fetch_addr), .Fetch_data(f_f),
      .Req(Req), .MemWrite(MemWrite), .Byte_en(Byte_en), .Address(Address),
      .Write_data(Write_data), .Ready(rdy_f), .Mem_data(md_f), .Rvalid(rv_f),
      .Resp_err(er_f), .Clear_req(Clear_req), .Busy(bz_f));

   // The no-data-region build must never report a clear in progress.
   always @(negedge clk) if (bz_f !== 1'b0) full_busy_seen = 1'b1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One access, presented for one edge; outputs sampled 1 time unit after it.
   task automatic access(input logic we, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd);
      Req = 1'b1; MemWrite = we; Address = a; Byte_en = be; Write_data = wd;
      @(posedge clk); #1;
   endtask

   task automatic idle();
      Req = 1'b0; MemWrite = 1'b0; Clear_req = 1'b0;
   endtask

   // Counts cycles with Busy high (bounded); notes any Rvalid seen meanwhile.
   task automatic wait_clear(output int n, output bit rv_seen);
      n = 0; rv_seen = 1'b0;
      while (bz_n === 1'b1 && n < 300) begin
         n++;
         @(posedge clk); #1;
         if (rv_n === 1'b1 || rv_a === 1'b1) rv_seen = 1'b1;
      end
   endtask

   initial begin
      int  n;
      bit  rvs;
      reset = 1'b0; Fetch_addr = '0; Address = '0; Byte_en = '0; Write_data = '0;
      idle();
      repeat (3) @(posedge clk);
      #1;
      // Reset state
      chk("rst_ready",   {31'b0, rdy_a}, 32'd0);
      chk("rst_busy",    {31'b0, bz_a},  32'd1);
      chk("rst_rvalid",  {31'b0, rv_a},  32'd0);
      chk("rst_err",     {31'b0, er_a},  32'd0);
      chk("rst_mdata",   md_a,           32'd0);
      chk("full_rst_rdy",{31'b0, rdy_f}, 32'd1);

      reset = 1'b1;
      chk("full_rdy_rel",{31'b0, rdy_f}, 32'd1);
      wait_clear(n, rvs);
      chk("clear0_len", n, 32'd224);
      chk("clear0_ready", {31'b0, rdy_n}, 32'd1);

      // Preload instruction word 5 (unprotected build) and data word 40
      access(1'b1, 32'h14, 4'hF, 32'h12345678);
      chk("pre_w5_err_nw", {31'b0, er_n}, 32'd0);
      chk("pre_w5_err_wp", {31'b0, er_a}, 32'd1);
      access(1'b1, 32'hA0, 4'hF, 32'hDEADBEEF);
      chk("pre_w40_rv", {31'b0, rv_n}, 32'd1);
      idle();
      Fetch_addr = 32'hA0; #1;
      chk("pre_fetch40", f_n, 32'hDEADBEEF);

      // Reset pulse: full clear again, instruction region retained
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      wait_clear(n, rvs);
      chk("clear1_len", n, 32'd224);
      access(1'b0, 32'hA0, 4'h0, 32'h0);
      idle();
      chk("rd40_rv",   {31'b0, rv_n}, 32'd1);
      chk("rd40_data", md_n,          32'd0);
      Fetch_addr = 32'h14; #1;
      chk("fetch_w5",  f_n, 32'h12345678);
      Fetch_addr = 32'h400; #1;
      chk("fetch_oor", f_n, 32'd0);

      // Byte-enable write then back-to-back read of the same word
      access(1'b1, 32'h100, 4'b0101, 32'hAABBCCDD);
      chk("bw_rv",    {31'b0, rv_a}, 32'd1);
      chk("bw_err",   {31'b0, er_a}, 32'd0);
      chk("bw_mkeep", md_n,          32'd0);
      access(1'b0, 32'h100, 4'h0, 32'h0);
      chk("br_rv",    {31'b0, rv_a}, 32'd1);
      chk("br_data",  md_a,          32'h00BB00DD);
      chk("br_err",   {31'b0, er_a}, 32'd0);

      // Error responses, back-to-back with good reads in between
      access(1'b0, 32'h102, 4'h0, 32'h0);
      chk("mis_err",  {31'b0, er_a}, 32'd1);
      chk("mis_data", md_a,          32'd0);
      access(1'b0, 32'h100, 4'h0, 32'h0);
      chk("rd2_data", md_a,          32'h00BB00DD);
      access(1'b0, 32'h400, 4'h0, 32'h0);
      chk("oor_err",  {31'b0, er_a}, 32'd1);
      chk("oor_rv",   {31'b0, rv_a}, 32'd1);
      chk("oor_data", md_a,          32'd0);
      access(1'b0, 32'h100, 4'h0, 32'h0);
      access(1'b1, 32'h10, 4'hF, 32'hFFFFFFFF);
      chk("wp_err",     {31'b0, er_a}, 32'd1);
      chk("wp_data",    md_a,          32'd0);
      chk("nwp_err",    {31'b0, er_n}, 32'd0);
      chk("nwp_mkeep",  md_n,          32'h00BB00DD);
      access(1'b1, 32'h104, 4'h0, 32'hFFFFFFFF);
      chk("be0_err",    {31'b0, er_a}, 32'd0);
      idle();
      Fetch_addr = 32'h10; #1;
      chk("wp_word4",   {31'b0, f_a === 32'hFFFFFFFF}, 32'd0);
      chk("nwp_word4",  f_n, 32'hFFFFFFFF);
      Fetch_addr = 32'h104; #1;
      chk("be0_word65", f_a, 32'd0);
      @(posedge clk); #1;
      chk("idle_rv",    {31'b0, rv_a}, 32'd0);
      chk("idle_err",   {31'b0, er_a}, 32'd0);

      // Access and Clear_req in the same cycle: access completes, then clear
      Clear_req = 1'b1;
      access(1'b0, 32'h100, 4'h0, 32'h0);
      idle();
      chk("rc_rv",   {31'b0, rv_a}, 32'd1);
      chk("rc_data", md_a,          32'h00BB00DD);
      chk("rc_busy", {31'b0, bz_a}, 32'd1);
      wait_clear(n, rvs);
      chk("clear2_len", n, 32'd224);
      Fetch_addr = 32'h100; #1;
      chk("clr_w64", f_a, 32'd0);
      Fetch_addr = 32'h14; #1;
      chk("clr_w5",  f_n, 32'h12345678);

      // Reset 100 cycles into a clear, with Req held the whole time
      Clear_req = 1'b1;
      @(posedge clk); #1;
      Clear_req = 1'b0;
      Req = 1'b1; Address = 32'h100;
      rvs = 1'b0;
      for (int i = 0; i < 99; i++) begin
         @(posedge clk); #1;
         if (rv_a === 1'b1) rvs = 1'b1;
      end
      chk("mid_busy", {31'b0, bz_a}, 32'd1);
      reset = 1'b0; #1;
      chk("mid_rst_mdata", md_a, 32'd0);
      chk("mid_rst_rdy", {31'b0, rdy_a}, 32'd0);
      @(posedge clk); #1;
      reset = 1'b1;
      wait_clear(n, rvs);
      Req = 1'b0;
      chk("clear3_len", n, 32'd224);
      chk("clear3_no_rv", {31'b0, rvs}, 32'd0);
      chk("full_never_busy", {31'b0, full_busy_seen}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
